// File: rtl/uart_pkg.sv
// uart_pkg: shared types, oversampling constants and framing helpers for the UART transceiver
package uart_pkg;
    localparam int OVS = 16;
    localparam int SAMPLE_MID = 8;

    typedef enum logic [2:0] {PAR_NONE, PAR_ODD, PAR_EVEN, PAR_MARK, PAR_SPACE} par_t;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT_HI} rx_state_t;
    typedef struct packed {logic brk; logic frm; logic par;} rx_err_t;

    function automatic par_t par_decode(logic [2:0] p);
        return (p > 3'd4) ? PAR_NONE : par_t'(p);
    endfunction

    function automatic logic [7:0] dmask(logic [1:0] dlen, logic [7:0] d);
        return d & (8'hFF >> (2'd3 - dlen));
    endfunction

    function automatic logic par_bit(par_t p, logic [7:0] d);
        return (p == PAR_ODD) ? ~^d : (p == PAR_EVEN) ? ^d : (p == PAR_MARK);
    endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: first-word-fall-through synchronous FIFO with flush and occupancy count
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      level,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp, r_rp;
    logic             w_push, w_pop;

    assign full   = level[AW];
    assign empty  = level == '0;
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign rdata  = empty ? '0 : r_mem[r_rp];

    // storage carries no reset; the pointers alone decide what is valid
    always_ff @(posedge clk)
        if (w_push && !flush) r_mem[r_wp] <= wdata;

    // pointers and occupancy; a flush overrides any same-cycle push or pop
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            level <= '0;
        end else if (flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            level <= '0;
        end else begin
            r_wp  <= r_wp + AW'(w_push);
            r_rp  <= r_rp + AW'(w_pop);
            level <= level + LW'(w_push) - LW'(w_pop);
        end
endmodule

// File: rtl/uart_xcvr.sv
// uart_xcvr: 16x-oversampled UART transceiver with FIFOs, parity, break detect and idle timeout
module uart_xcvr
    import uart_pkg::*;
#(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16,
    parameter int DIV_W = 16,
    parameter int TOUT_BITS = 40,
    localparam int TLW = $clog2(TX_DEPTH) + 1,
    localparam int RLW = $clog2(RX_DEPTH) + 1,
    localparam int TW = $clog2(TOUT_BITS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [1:0]       cfg_dlen,
    input  logic             cfg_stop2,
    input  logic [2:0]       cfg_par,
    input  logic             cfg_loop,
    input  logic [TLW-1:0]   cfg_tx_trig,
    input  logic [RLW-1:0]   cfg_rx_trig,
    input  logic             tx_flush,
    input  logic             rx_flush,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic [2:0]       rx_err,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [TLW-1:0]   tx_level,
    output logic [RLW-1:0]   rx_level,
    output logic             tx_busy,
    output logic             ovrn,
    output logic             irq_tx,
    output logic             irq_rx,
    output logic             irq_tout,
    output logic             TX,
    input  logic             RX
);
    logic [DIV_W-1:0] r_div_cnt;
    logic             w_tick;
    logic [7:0]       w_tx_head;
    logic             w_tx_full, w_tx_empty, w_tx_pop, w_tx_bit_end, w_tx_stop_end, w_tx_line;
    tx_state_t        r_tx_state;
    logic [3:0]       r_tx_cnt;
    logic [2:0]       r_tx_bit;
    logic [7:0]       r_tx_sh;
    logic [1:0]       r_tx_dlen;
    logic             r_tx_stop2, r_tx_pbit;
    par_t             r_tx_par;
    logic             r_s1, r_s2, r_s3;
    rx_state_t        r_rx_state;
    logic [3:0]       r_rx_cnt;
    logic [2:0]       r_rx_bit;
    logic [7:0]       r_rx_sh;
    logic [1:0]       r_rx_smp;
    logic             r_rx_pbit, r_rx_any1, r_ovrn;
    logic             w_rx_maj, w_rx_start, w_rx_done, w_rx_full, w_rx_empty, w_rx_pop;
    par_t             w_rx_par;
    logic [7:0]       w_rx_data;
    rx_err_t          w_err;
    logic [10:0]      w_rx_head;
    logic [3:0]       r_tout_sub;
    logic [TW-1:0]    r_tout_bits;
    logic             r_irq_tout;

    assign w_tick = r_div_cnt >= ((cfg_div == '0) ? '0 : cfg_div - DIV_W'(1));

    // free-running oversample divider shared by both directions
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_div_cnt <= '0;
        else r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);

    uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .flush(tx_flush), .push(tx_valid), .pop(w_tx_pop),
        .wdata(tx_data), .rdata(w_tx_head), .level(tx_level), .full(w_tx_full), .empty(w_tx_empty)
    );

    assign w_tx_bit_end  = w_tick && r_tx_cnt == 4'(OVS - 1);
    assign w_tx_stop_end = w_tx_bit_end && r_tx_state == TX_STOP && (!r_tx_stop2 || r_tx_bit[0]);
    assign w_tx_pop      = !w_tx_empty && ((w_tick && r_tx_state == TX_IDLE) || w_tx_stop_end);
    assign w_tx_line     = (r_tx_state == TX_START) ? 1'b0 : (r_tx_state == TX_DATA) ? r_tx_sh[0] :
                           (r_tx_state == TX_PAR) ? r_tx_pbit : 1'b1;
    assign TX            = cfg_loop | w_tx_line;
    assign tx_busy       = r_tx_state != TX_IDLE;
    assign tx_ready      = !w_tx_full;
    assign irq_tx        = tx_level <= cfg_tx_trig;

    // TX framer: latch byte and format on pop, then one bit per 16 ticks
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_sh    <= '0;
            r_tx_dlen  <= '0;
            r_tx_stop2 <= 1'b0;
            r_tx_par   <= PAR_NONE;
            r_tx_pbit  <= 1'b0;
        end else if (w_tx_pop) begin
            r_tx_state <= TX_START;
            r_tx_cnt   <= '0;
            r_tx_sh    <= w_tx_head;
            r_tx_dlen  <= cfg_dlen;
            r_tx_stop2 <= cfg_stop2;
            r_tx_par   <= par_decode(cfg_par);
            r_tx_pbit  <= par_bit(par_decode(cfg_par), dmask(cfg_dlen, w_tx_head));
        end else if (w_tick && r_tx_state != TX_IDLE) begin
            r_tx_cnt <= r_tx_cnt + 4'd1;
            if (w_tx_bit_end)
                case (r_tx_state)
                    TX_START: begin
                        r_tx_state <= TX_DATA;
                        r_tx_bit   <= '0;
                    end
                    TX_DATA: begin
                        r_tx_sh  <= r_tx_sh >> 1;
                        r_tx_bit <= r_tx_bit + 3'd1;
                        if (r_tx_bit == 3'(r_tx_dlen) + 3'd4) begin
                            r_tx_state <= (r_tx_par == PAR_NONE) ? TX_STOP : TX_PAR;
                            r_tx_bit   <= '0;
                        end
                    end
                    TX_PAR: begin
                        r_tx_state <= TX_STOP;
                        r_tx_bit   <= '0;
                    end
                    default: begin
                        r_tx_bit <= r_tx_bit + 3'd1;
                        if (w_tx_stop_end) r_tx_state <= TX_IDLE;
                    end
                endcase
        end

    // two-stage synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= cfg_loop ? w_tx_line : RX;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end

    assign w_rx_maj   = (r_rx_smp[1] & r_rx_smp[0]) | (r_rx_smp[1] & r_s2) | (r_rx_smp[0] & r_s2);
    assign w_rx_start = r_rx_state == RX_IDLE && r_s3 && !r_s2;
    assign w_rx_done  = w_tick && r_rx_state == RX_STOP && r_rx_cnt == 4'(SAMPLE_MID + 1);
    assign w_rx_par   = par_decode(cfg_par);
    assign w_rx_data  = r_rx_sh >> (2'd3 - cfg_dlen);

    // frame status at the stop-bit vote; a break reports every flag
    always_comb begin
        w_err.frm = !w_rx_maj;
        w_err.brk = !w_rx_maj && !r_rx_any1;
        w_err.par = w_err.brk || (w_rx_par != PAR_NONE && r_rx_pbit != par_bit(w_rx_par, w_rx_data));
    end

    // RX deframer: vote samples 7/8/9 of each bit, finish mid-stop to catch back-to-back starts
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_sh    <= '0;
            r_rx_smp   <= '0;
            r_rx_pbit  <= 1'b0;
            r_rx_any1  <= 1'b0;
        end else if (w_rx_start) begin
            r_rx_state <= RX_START;
            r_rx_cnt   <= '0;
            r_rx_any1  <= 1'b0;
        end else if (w_tick && r_rx_state != RX_IDLE) begin
            r_rx_cnt <= r_rx_cnt + 4'd1;
            if (r_rx_cnt == 4'(SAMPLE_MID - 1) || r_rx_cnt == 4'(SAMPLE_MID))
                r_rx_smp <= {r_rx_smp[0], r_s2};
            if (r_rx_state == RX_WAIT_HI) begin
                r_rx_cnt <= r_s2 ? r_rx_cnt + 4'd1 : '0;
                if (r_s2 && r_rx_cnt == 4'(OVS - 1)) r_rx_state <= RX_IDLE;
            end else if (r_rx_cnt == 4'(SAMPLE_MID + 1)) begin
                r_rx_any1 <= r_rx_any1 | w_rx_maj;
                case (r_rx_state)
                    RX_START: if (w_rx_maj) r_rx_state <= RX_IDLE;
                    RX_DATA:  r_rx_sh <= {w_rx_maj, r_rx_sh[7:1]};
                    RX_PAR:   r_rx_pbit <= w_rx_maj;
                    default: begin
                        r_rx_state <= w_err.brk ? RX_WAIT_HI : RX_IDLE;
                        r_rx_cnt   <= '0;
                    end
                endcase
            end else if (r_rx_cnt == 4'(OVS - 1))
                case (r_rx_state)
                    RX_START: begin
                        r_rx_state <= RX_DATA;
                        r_rx_bit   <= '0;
                    end
                    RX_DATA: begin
                        r_rx_bit <= r_rx_bit + 3'd1;
                        if (r_rx_bit == 3'(cfg_dlen) + 3'd4)
                            r_rx_state <= (w_rx_par == PAR_NONE) ? RX_STOP : RX_PAR;
                    end
                    RX_PAR:  r_rx_state <= RX_STOP;
                    default: ;
                endcase
        end

    uart_sync_fifo #(.WIDTH(11), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .flush(rx_flush), .push(w_rx_done), .pop(w_rx_pop),
        .wdata({w_err, w_rx_data}), .rdata(w_rx_head), .level(rx_level), .full(w_rx_full), .empty(w_rx_empty)
    );

    assign w_rx_pop = rx_valid && rx_ready;
    assign rx_valid = !w_rx_empty;
    assign rx_data  = w_rx_head[7:0];
    assign rx_err   = w_rx_head[10:8];
    assign irq_rx   = cfg_rx_trig != '0 && rx_level >= cfg_rx_trig;
    assign ovrn     = r_ovrn;
    assign irq_tout = r_irq_tout;

    // overrun pulse when a completed frame finds the RX FIFO full
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_ovrn <= 1'b0;
        else r_ovrn <= w_rx_done && w_rx_full;

    // idle timeout in bit times while data waits and the line is quiet
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_tout_sub  <= '0;
            r_tout_bits <= '0;
            r_irq_tout  <= 1'b0;
        end else begin
            if (w_rx_done || w_rx_pop || rx_flush) begin
                r_tout_sub  <= '0;
                r_tout_bits <= '0;
            end else if (w_tick && !w_rx_empty && r_rx_state == RX_IDLE && r_tout_bits != TW'(TOUT_BITS)) begin
                r_tout_sub <= r_tout_sub + 4'd1;
                if (r_tout_sub == 4'(OVS - 1)) r_tout_bits <= r_tout_bits + TW'(1);
            end
            if (w_rx_pop || rx_flush || w_rx_start) r_irq_tout <= 1'b0;
            else if (r_tout_bits == TW'(TOUT_BITS)) r_irq_tout <= 1'b1;
        end
endmodule

// File: tb/tb_uart_xcvr.sv
// tb_uart_xcvr: scoreboard bench for the UART transceiver (loopback, pin framing, errors, overrun, break, timeout, flush)
module tb_uart_xcvr;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [15:0] cfg_div = 16'd1;
    logic [1:0]  cfg_dlen = 2'd3;
    logic        cfg_stop2 = 1'b0, cfg_loop = 1'b0;
    logic [2:0]  cfg_par = 3'd0;
    logic [4:0]  cfg_tx_trig = 5'd0;
    logic [2:0]  cfg_rx_trig = 3'd0;
    logic        tx_flush = 1'b0, rx_flush = 1'b0, tx_valid = 1'b0, rx_ready = 1'b0, RX = 1'b1;
    logic [7:0]  tx_data = 8'd0;
    logic        tx_ready, rx_valid, tx_busy, ovrn, irq_tx, irq_rx, irq_tout, TX;
    logic [7:0]  rx_data;
    logic [2:0]  rx_err;
    logic [4:0]  tx_level;
    logic [2:0]  rx_level;
    int          n_cmp = 0, n_bad = 0, n_ovrn = 0;
    logic [10:0] exp_q[$];

    uart_xcvr #(.TX_DEPTH(16), .RX_DEPTH(4), .DIV_W(16), .TOUT_BITS(40)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_div(cfg_div), .cfg_dlen(cfg_dlen), .cfg_stop2(cfg_stop2),
        .cfg_par(cfg_par), .cfg_loop(cfg_loop), .cfg_tx_trig(cfg_tx_trig), .cfg_rx_trig(cfg_rx_trig),
        .tx_flush(tx_flush), .rx_flush(rx_flush), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_err(rx_err), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .tx_level(tx_level), .rx_level(rx_level), .tx_busy(tx_busy),
        .ovrn(ovrn), .irq_tx(irq_tx), .irq_rx(irq_rx), .irq_tout(irq_tout), .TX(TX), .RX(RX)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (ovrn) n_ovrn++;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_tx(logic [7:0] d);
        tx_data = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic send_bit(logic b);
        RX = b;
        repeat (16) @(negedge clk);
    endtask

    task automatic send_frame(logic [7:0] d, int nb, bit has_p, logic p, logic stop);
        send_bit(1'b0);
        for (int i = 0; i < nb; i++) send_bit(d[i]);
        if (has_p) send_bit(p);
        send_bit(stop);
        send_bit(1'b1);
    endtask

    task automatic pop_chk(string tag);
        logic [10:0] e;
        int n;
        n = 0;
        while (!rx_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, rx_valid, 1);
        if (rx_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_data"}, rx_data, e[7:0]);
            check({tag, "_err"}, rx_err, e[10:8]);
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
        end
    endtask

    initial begin
        int t, base;
        logic [8:0] seq;
        repeat (3) @(negedge clk);
        check("rst_tx", TX, 1);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_err", rx_err, 0);
        check("rst_tx_level", tx_level, 0);
        check("rst_rx_level", rx_level, 0);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_ovrn", ovrn, 0);
        check("rst_irq_tout", irq_tout, 0);
        check("rst_irq_tx", irq_tx, 1);
        check("rst_irq_rx", irq_rx, 0);
        rst_n = 1'b1;
        @(negedge clk);

        cfg_loop = 1'b1;
        exp_q.push_back({3'b000, 8'h55});
        push_tx(8'h55);
        for (int i = 0; i < 50 && !tx_busy; i++) @(negedge clk);
        t = 0;
        while (tx_busy && t < 400) begin
            t++;
            @(negedge clk);
        end
        check("busy_len", t, 160);
        pop_chk("loop55");

        cfg_dlen = 2'd2;
        cfg_par = 3'd2;
        exp_q.push_back({3'b000, 8'h3A});
        exp_q.push_back({3'b000, 8'h7F});
        push_tx(8'h3A);
        push_tx(8'h7F);
        pop_chk("loop7e1_a");
        pop_chk("loop7e1_b");
        for (int i = 0; i < 400 && tx_busy; i++) @(negedge clk);

        cfg_loop = 1'b0;
        cfg_par = 3'd1;
        cfg_dlen = 2'd0;
        cfg_stop2 = 1'b1;
        seq = 9'b110111110;
        push_tx(8'h1F);
        t = 0;
        while (TX && t < 100) begin
            t++;
            @(negedge clk);
        end
        check("pin_start", TX, 0);
        repeat (8) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("pin_bit%0d", i), TX, seq[i]);
            repeat (16) @(negedge clk);
        end
        for (int i = 0; i < 400 && tx_busy; i++) @(negedge clk);
        check("pin_idle", tx_busy, 0);

        cfg_par = 3'd2;
        cfg_dlen = 2'd3;
        cfg_stop2 = 1'b0;
        exp_q.push_back({3'b001, 8'hA5});
        send_frame(8'hA5, 8, 1'b1, 1'b1, 1'b1);
        pop_chk("par_err");

        cfg_par = 3'd0;
        exp_q.push_back({3'b010, 8'h0F});
        send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b0);
        pop_chk("frm_err");

        cfg_rx_trig = 3'd2;
        base = n_ovrn;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back({3'b000, 8'(8'h11 * (i + 1))});
            send_frame(8'(8'h11 * (i + 1)), 8, 1'b0, 1'b0, 1'b1);
        end
        check("ovr_level", rx_level, 4);
        check("ovr_pulses", n_ovrn - base, 1);
        check("ovr_irq_rx", irq_rx, 1);
        for (int i = 0; i < 4; i++) pop_chk($sformatf("ovr%0d", i));
        check("ovr_drained", rx_level, 0);
        check("ovr_irq_rx_low", irq_rx, 0);
        cfg_rx_trig = 3'd0;

        RX = 1'b0;
        repeat (480) @(negedge clk);
        check("brk_level", rx_level, 1);
        RX = 1'b1;
        repeat (40) @(negedge clk);
        check("brk_level_hi", rx_level, 1);
        exp_q.push_back({3'b111, 8'h00});
        pop_chk("brk");
        exp_q.push_back({3'b000, 8'h3C});
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
        pop_chk("post_brk");

        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(8'h42 >> i);
        RX = 1'b1;
        t = 0;
        while (!rx_valid && t < 100) begin
            t++;
            @(negedge clk);
        end
        check("tout_valid", rx_valid, 1);
        check("tout_data", rx_data, 8'h42);
        t = 0;
        while (!irq_tout && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("tout_delay_ok", (t >= 638 && t <= 644), 1);
        rx_flush = 1'b1;
        @(negedge clk);
        rx_flush = 1'b0;
        check("flush_rx_level", rx_level, 0);
        check("flush_irq_tout", irq_tout, 0);
        check("flush_rx_valid", rx_valid, 0);

        cfg_tx_trig = 5'd1;
        tx_data = 8'hA1;
        tx_valid = 1'b1;
        repeat (3) @(negedge clk);
        tx_valid = 1'b0;
        check("txf_level", tx_level, 2);
        check("txf_irq_tx", irq_tx, 0);
        tx_flush = 1'b1;
        tx_data = 8'hB2;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_flush = 1'b0;
        tx_valid = 1'b0;
        check("txf_flushed", tx_level, 0);
        check("txf_irq_tx_hi", irq_tx, 1);
        check("txf_ready", tx_ready, 1);
        for (int i = 0; i < 400 && tx_busy; i++) @(negedge clk);
        check("txf_idle", tx_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
